instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_OPCODE, default 6'b111111: instr[31:26] value that halts fetch.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; port clk (in, 1) is the sole clock and all state updates on its rising edge.
REQ-004 The block SHALL have port reset (in, 1): synchronous, active-high reset.
REQ-005 The block SHALL have port stall (in, 1): hold PC and IF/ID register.
REQ-006 The block SHALL have port flush (in, 1): load a bubble into IF/ID.
REQ-007 The block SHALL have port redirect_valid (in, 1): branch/jump taken this cycle.
REQ-008 The block SHALL have port redirect_target (in, 32): new PC when redirect_valid=1.
REQ-009 The block SHALL have port imem_addr (out, 32): byte address to instruction memory, equal to current PC.
REQ-010 The block SHALL have port imem_instr (in, 32): big-endian word returned combinationally for imem_addr.
REQ-011 The block SHALL have ports if_instr (out, 32), if_pc (out, 32), if_pc_plus4 (out, 32) and if_valid (out, 1): IF/ID register contents.
REQ-012 The block SHALL have port halted (out, 1): FSM is in HALT.
REQ-013 The block SHALL have port fetch_count (out, 32): count of valid instructions captured into IF/ID.

Function
REQ-014 The FSM SHALL have two states, RUN and HALT; PC advances only in RUN.
REQ-015 Per-edge priority SHALL be reset > redirect > stall > normal.
REQ-016 Normal RUN edge: PC <= PC+4 (mod 2^32); IF/ID <= {imem_instr, PC, PC+4}; if_valid <= 1.
REQ-017 Latency SHALL be one cycle: the word at address A appears on if_instr the edge after imem_addr=A.
REQ-018 Stall edge (no redirect, no flush): PC and all IF/ID fields SHALL hold.
REQ-019 Flush edge: if_valid <= 0 and if_instr <= 0 regardless of stall; PC follows the stall/redirect rules.
REQ-020 Redirect edge: PC <= redirect_target and if_valid <= 0, even when stall=1 (redirect overrides stall).
REQ-021 HALT entry: when a word with instr[31:26]=HALT_OPCODE is captured with if_valid<=1, the FSM SHALL enter HALT on that same edge and PC holds.
REQ-022 In HALT without redirect: PC holds, if_valid <= 0 on the next non-stall edge, and halted=1.
REQ-023 Redirect in HALT: FSM SHALL return to RUN and PC <= redirect_target, because the halt was speculative.
REQ-024 fetch_count SHALL increment on each edge that writes if_valid <= 1, and SHALL saturate at 32'hFFFF_FFFF.
REQ-025 PC wrap-around from 32'hFFFF_FFFC SHALL give 32'h0000_0000 with no flag.

Reset
REQ-026 On a reset edge, PC SHALL be set to RESET_PC and the FSM to RUN.
REQ-027 On a reset edge, if_instr, if_pc, if_pc_plus4 and fetch_count SHALL be set to 0, and if_valid and halted to 0.
REQ-028 Reset asserted mid-stall, mid-redirect or in HALT SHALL override all other inputs on that edge.
REQ-029 The first valid if_instr SHALL be the word at RESET_PC, one edge after reset deasserts.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN defined: output align_fault (out, 1) exists and reset value is 0.
REQ-031 With FETCH_ALIGN_CHECK_EN, a redirect with target[1:0]!=0 SHALL load PC with target[1:0] forced to 00 and SHALL assert align_fault for exactly one cycle.
REQ-032 Macro FETCH_ALIGN_CHECK_EN undefined: port align_fault SHALL be absent and redirect_target SHALL be loaded unmodified.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the RUN/HALT state encodings, HALT_OPCODE default and the bubble word 32'h0000_0000.
REQ-034 The IF/ID register SHALL be sub-module if_id_reg, with stall and flush inputs and a valid bit; PC, FSM and counter SHALL stay in the top level.

Verification
REQ-035 Bench scenario, reset then 4 free-running cycles with RESET_PC=0: if_pc SHALL be 0, 4, 8, 12, if_valid=1 from the 1st edge, and fetch_count=4.
REQ-036 Bench scenario, stall=1 for 3 cycles at PC=8: imem_addr SHALL stay 8, IF/ID SHALL hold, fetch_count SHALL be unchanged, and fetch SHALL resume at 8.
REQ-037 Bench scenario, redirect_valid=1, target=0x40, with stall=1 on the same edge: next imem_addr SHALL be 0x40 and if_valid SHALL be 0, then if_pc=0x40.
REQ-038 Bench scenario, word 0xFC000000 at address 0x10: halted=1 after capture and imem_addr SHALL stay frozen; a later redirect to 0x20 SHALL give halted=0 and if_pc=0x20.
REQ-039 Bench scenario, flush=1 with stall=1: if_valid SHALL be 0 and PC SHALL be held; then flush during normal fetch SHALL give one bubble and no gap in PC.
REQ-040 Bench scenario with FETCH_ALIGN_CHECK_EN, redirect to 0x42: PC SHALL be 0x40, align_fault SHALL be 1 for one cycle, and reset SHALL then clear align_fault.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants for the instruction fetch stage: FSM state
//               encodings, default halt opcode and the IF/ID bubble word.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [0:0]  c_ST_RUN       = 1'b0;
    localparam logic [0:0]  c_ST_HALT      = 1'b1;
    localparam logic [5:0]  c_HALT_OPCODE  = 6'b111111;
    localparam logic [31:0] c_BUBBLE       = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with hold (stall) and bubble (flush).
//               Flush wins over stall; PC fields hold during a flush.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= c_BUBBLE;
            r_pc       <= 32'h0000_0000;
            r_pc_plus4 <= 32'h0000_0000;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= c_BUBBLE;
            r_valid    <= 1'b0;
        end else if (!i_stall) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= i_valid;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : PC register, RUN/HALT fetch FSM and fetch counter feeding the
//               IF/ID register. Optional FETCH_ALIGN_CHECK_EN adds align_fault
//               and forces redirect targets to word alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = c_HALT_OPCODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        halted,
    output logic [31:0] fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        align_fault
`endif
);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic [31:0] r_fetch_count;
    logic        w_capture;
    logic        w_is_halt;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_is_halt  = (imem_instr[31:26] == HALT_OPCODE);

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_align_fault;
    assign w_redirect_pc = {redirect_target[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_align_fault <= 1'b0;
        end else begin
            r_align_fault <= redirect_valid && (redirect_target[1:0] != 2'b00);
        end
    end

    assign align_fault = r_align_fault;
`else
    assign w_redirect_pc = redirect_target;
`endif

    // A capture is the only event that writes a valid word into IF/ID.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        if (redirect_valid) begin
            w_state_nxt = c_ST_RUN;
            w_pc_nxt    = w_redirect_pc;
        end else if (!stall && (r_state == c_ST_RUN)) begin
            w_capture = !flush;
            if (w_capture && w_is_halt) begin
                w_state_nxt = c_ST_HALT;
            end else begin
                w_pc_nxt = w_pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_RUN;
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    // Redirect squashes the IF/ID slot just like an explicit flush.
    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (reset),
        .i_stall    (stall),
        .i_flush    (flush | redirect_valid),
        .i_valid    (w_capture),
        .i_instr    (w_capture ? imem_instr : c_BUBBLE),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (if_instr),
        .o_pc       (if_pc),
        .o_pc_plus4 (if_pc_plus4),
        .o_valid    (if_valid)
    );

    assign imem_addr   = r_pc;
    assign halted      = (r_state == c_ST_HALT);
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        halted;
    logic [31:0] fetch_count;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    int   n_tests;
    int   n_fail;
    logic halt_word_en;

    instruction_fetch #(
        .RESET_PC    (32'h0000_0000),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .if_valid        (if_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .align_fault     (align_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: distinct non-halting word per address, halt word at 0x10 on demand.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_word_en && (a == 32'h10)) return 32'hFC00_0000;
        return 32'h1000_0000 | (a & 32'h00FF_FFFF);
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        halt_word_en    = 1'b0;
        reset           = 1'b1;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        tick();
        tick();
        chk("rst_valid",  {31'd0, if_valid}, 32'd0);
        chk("rst_instr",  if_instr, 32'h0);
        chk("rst_pc",     if_pc, 32'h0);
        chk("rst_pc4",    if_pc_plus4, 32'h0);
        chk("rst_count",  fetch_count, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_addr",   imem_addr, 32'h0);

        // Free-running fetch from RESET_PC.
        reset = 1'b0;
        tick();
        chk("run0_pc",    if_pc, 32'h0);
        chk("run0_valid", {31'd0, if_valid}, 32'd1);
        chk("run0_instr", if_instr, 32'h1000_0000);
        chk("run0_pc4",   if_pc_plus4, 32'h4);
        tick();
        chk("run1_pc", if_pc, 32'h4);
        tick();
        chk("run2_pc", if_pc, 32'h8);
        tick();
        chk("run3_pc",    if_pc, 32'hC);
        chk("run3_count", fetch_count, 32'd4);
        chk("run3_addr",  imem_addr, 32'h10);

        // Stall three cycles at PC=8.
        redirect_valid = 1'b1; redirect_target = 32'h4;
        tick();
        chk("redir4_addr",  imem_addr, 32'h4);
        chk("redir4_valid", {31'd0, if_valid}, 32'd0);
        chk("redir4_count", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        tick();
        chk("pre_stall_addr", imem_addr, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr",  imem_addr, 32'h8);
            chk("stall_pc",    if_pc, 32'h4);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_count", fetch_count, 32'd5);
        end
        stall = 1'b0;
        tick();
        chk("resume_pc",    if_pc, 32'h8);
        chk("resume_instr", if_instr, 32'h1000_0008);
        chk("resume_count", fetch_count, 32'd6);

        // Redirect overrides stall.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        tick();
        chk("rs_addr",  imem_addr, 32'h40);
        chk("rs_valid", {31'd0, if_valid}, 32'd0);
        chk("rs_count", fetch_count, 32'd6);
        stall = 1'b0; redirect_valid = 1'b0;
        tick();
        chk("rs_pc",    if_pc, 32'h40);
        chk("rs_valid2", {31'd0, if_valid}, 32'd1);
        chk("rs_count2", fetch_count, 32'd7);

        // Flush with stall, then flush during normal fetch.
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("fs_valid", {31'd0, if_valid}, 32'd0);
        chk("fs_instr", if_instr, 32'h0);
        chk("fs_addr",  imem_addr, 32'h44);
        stall = 1'b0;
        tick();
        chk("fn_valid", {31'd0, if_valid}, 32'd0);
        chk("fn_addr",  imem_addr, 32'h48);
        chk("fn_count", fetch_count, 32'd7);
        flush = 1'b0;
        tick();
        chk("fa_pc",    if_pc, 32'h48);
        chk("fa_valid", {31'd0, if_valid}, 32'd1);
        chk("fa_count", fetch_count, 32'd8);

        // Halt on opcode 6'b111111 at 0x10.
        halt_word_en = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'hC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("h_pre_pc", if_pc, 32'hC);
        tick();
        chk("h_halted", {31'd0, halted}, 32'd1);
        chk("h_addr",   imem_addr, 32'h10);
        chk("h_instr",  if_instr, 32'hFC00_0000);
        chk("h_valid",  {31'd0, if_valid}, 32'd1);
        chk("h_count",  fetch_count, 32'd10);
        tick();
        chk("h2_halted", {31'd0, halted}, 32'd1);
        chk("h2_addr",   imem_addr, 32'h10);
        chk("h2_valid",  {31'd0, if_valid}, 32'd0);
        chk("h2_count",  fetch_count, 32'd10);
        redirect_valid = 1'b1; redirect_target = 32'h20;
        tick();
        chk("hr_halted", {31'd0, halted}, 32'd0);
        chk("hr_addr",   imem_addr, 32'h20);
        redirect_valid = 1'b0;
        tick();
        chk("hr_pc",    if_pc, 32'h20);
        chk("hr_valid", {31'd0, if_valid}, 32'd1);

        // PC wrap-around.
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_pc",   if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4",  if_pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset dominates stall and redirect.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80; reset = 1'b1;
        tick();
        chk("rr_addr",  imem_addr, 32'h0);
        chk("rr_valid", {31'd0, if_valid}, 32'd0);
        chk("rr_count", fetch_count, 32'd0);
        chk("rr_pc",    if_pc, 32'h0);
        stall = 1'b0; redirect_valid = 1'b0; reset = 1'b0;
        tick();

        // Misaligned redirect target.
        redirect_valid = 1'b1; redirect_target = 32'h42;
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("al_addr",  imem_addr, 32'h40);
        chk("al_fault", {31'd0, align_fault}, 32'd1);
        redirect_valid = 1'b0;
        tick();
        chk("al_fault_1cyc", {31'd0, align_fault}, 32'd0);
        chk("al_pc",         if_pc, 32'h40);
        redirect_valid = 1'b1;
        tick();
        chk("al_fault2", {31'd0, align_fault}, 32'd1);
        reset = 1'b1;
        tick();
        chk("al_rst_fault", {31'd0, align_fault}, 32'd0);
        reset = 1'b0; redirect_valid = 1'b0;
`else
        chk("na_addr", imem_addr, 32'h42);
        redirect_valid = 1'b0;
        tick();
        chk("na_pc", if_pc, 32'h42);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
